im_access_arbiter: RTL and testbench

- Sits between the F-stage fetch port and the single-port synchronous instruction memory array.
- Shares that memory with a loader/debug port, which can read, write and take exclusive lock.
- Translates fetch byte PCs (base 0x0000_3000) into word indices, detects out-of-range fetches, and applies a starvation guard so that neither requester is locked out.

---
 rtl/im_pkg.sv | 13 +
 rtl/im_addr_xlate.sv | 35 +++
 rtl/im_access_arbiter.sv | 130 +++++++++++++
 tb/tb_im_access_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory access arbiter.
package im_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOCK = 2'd1,
        ST_REL  = 2'd2
    } im_state_e;

    localparam logic [31:0] IM_PC_BASE = 32'h0000_3000;
    localparam logic [31:0] IM_NOP     = 32'h0000_0000;

endpackage

// File: rtl/im_addr_xlate.sv
// Fetch/loader address translation: PC offset, word indices, range fault and,
// with IM_MISALIGN_TRAP_EN defined, a misaligned-fetch fault. Purely combinational.
module im_addr_xlate
    import im_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] PC_BASE = IM_PC_BASE
) (
    input  logic [31:0]       f_pc_i,
    input  logic [31:0]       l_addr_i,
    output logic [31:0]       off_o,
    output logic [ADDR_W-1:0] f_idx_o,
    output logic [ADDR_W-1:0] l_idx_o,
    output logic              range_flt_o,
    output logic              misalign_flt_o
);

    logic unused_l_bits;

    assign off_o   = f_pc_i - PC_BASE;
    assign f_idx_o = off_o[ADDR_W+1:2];
    assign l_idx_o = l_addr_i[ADDR_W+1:2];

    // PCs below the base wrap to huge offsets, so one upper-bit test covers both ends.
    assign range_flt_o = |off_o[31:ADDR_W+2];

`ifdef IM_MISALIGN_TRAP_EN
    assign misalign_flt_o = |f_pc_i[1:0];
`else
    assign misalign_flt_o = 1'b0;
`endif

    assign unused_l_bits = ^{l_addr_i[31:ADDR_W+2], l_addr_i[1:0]};

endmodule

// File: rtl/im_access_arbiter.sv
// Arbitrates fetch and loader ports onto one single-port sync instruction memory,
// with starvation guard and loader lock; optional IM_MISALIGN_TRAP_EN fetch trap.
module im_access_arbiter
    import im_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] PC_BASE    = IM_PC_BASE,
    parameter int          STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_pc,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_instr,
    output logic              f_fault,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    im_state_e         state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              f_pend_q, f_flt_q, l_pend_q;
    logic [31:0]       f_hold_q, l_hold_q;

    logic [31:0]       xl_off_unused;
    logic [ADDR_W-1:0] f_idx, l_idx;
    logic              range_flt, misalign_flt, f_flt;

    im_addr_xlate #(.ADDR_W(ADDR_W), .PC_BASE(PC_BASE)) u_xlate (
        .f_pc_i         (f_pc),
        .l_addr_i       (l_addr),
        .off_o          (xl_off_unused),
        .f_idx_o        (f_idx),
        .l_idx_o        (l_idx),
        .range_flt_o    (range_flt),
        .misalign_flt_o (misalign_flt)
    );

    assign f_flt = range_flt | misalign_flt;

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        case (state_q)
            ST_LOCK: l_gnt = l_req;
            ST_REL:  f_gnt = f_req;
            default: begin
                l_gnt = l_req && (!f_req || starve_q == STARVE_LIM);
                f_gnt = f_req && !l_gnt;
            end
        endcase
    end

    // Faulting fetches still take the grant slot but never touch the array.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = f_idx;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_en    = 1'b1;
            mem_we    = l_we;
            mem_addr  = l_idx;
            mem_wdata = l_wdata;
        end else if (f_gnt) begin
            mem_en = !f_flt;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_REL || l_gnt || !l_req) begin
            starve_d = '0;
        end else if (f_gnt && starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOCK: state_d = l_lock ? ST_LOCK : ST_REL;
            ST_REL:  state_d = l_lock ? ST_LOCK : ST_RUN;
            default: state_d = l_lock ? ST_LOCK : ST_RUN;
        endcase
    end

    assign f_rvalid = f_pend_q;
    assign f_fault  = f_flt_q;
    assign f_instr  = f_pend_q ? (f_flt_q ? IM_NOP : mem_rdata) : f_hold_q;
    assign l_rvalid = l_pend_q;
    assign l_rdata  = l_pend_q ? mem_rdata : l_hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            starve_q <= '0;
            f_pend_q <= 1'b0;
            f_flt_q  <= 1'b0;
            l_pend_q <= 1'b0;
            f_hold_q <= '0;
            l_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            f_pend_q <= f_gnt;
            f_flt_q  <= f_gnt && f_flt;
            l_pend_q <= l_gnt && !l_we;
            if (f_pend_q) f_hold_q <= f_instr;
            if (l_pend_q) l_hold_q <= l_rdata;
        end
    end

endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed plus random bench for im_access_arbiter against a behavioural port-level model.
module tb_im_access_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] f_pc = 32'h0, l_addr = 32'h0, l_wdata = 32'h0;
    logic        f_gnt, f_rvalid, f_fault, l_gnt, l_rvalid, mem_en, mem_we;
    logic [31:0] f_instr, l_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [11:0] mem_addr;

    int total = 0;
    int bad   = 0;

    im_access_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_pc(f_pc), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_instr(f_instr), .f_fault(f_fault),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ival(input logic [11:0] a);
        return 32'hA5C3_0000 ^ {8'h00, a, a};
    endfunction

    // Bench-side memory array driven by the DUT's mem_* strobes.
    logic [31:0] bmem [4096];
    bit          bwr  [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                bmem[mem_addr] <= mem_wdata;
                bwr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= bwr[mem_addr] ? bmem[mem_addr] : ival(mem_addr);
            end
        end
    end

    // Reference model state: its own memory image, mode flags, wait count, expected returns.
    logic [31:0] rmem [4096];
    bit          rwr  [4096];
    bit          m_locked, m_rel;
    int          m_waits;
    bit          p_frv, p_fflt, p_lrv;
    logic [31:0] p_fdat, p_ldat, h_f, h_l;

    function automatic logic [31:0] rd(input logic [11:0] a);
        return rwr[a] ? rmem[a] : ival(a);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_rel = 0; m_waits = 0;
        p_frv = 0; p_fflt = 0; p_lrv = 0;
        p_fdat = 0; p_ldat = 0; h_f = 0; h_l = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic fr, input logic [31:0] pc, input logic lr,
                        input logic lw, input logic lk, input logic [31:0] la,
                        input logic [31:0] wd);
        logic [31:0] off;
        logic        flt, eg_f, eg_l, e_en;
        logic [11:0] fidx, lidx;
        @(negedge clk);
        f_req = fr; f_pc = pc; l_req = lr; l_we = lw; l_lock = lk;
        l_addr = la; l_wdata = wd;
        #1;
        chk("f_rvalid", f_rvalid, p_frv);
        chk("l_rvalid", l_rvalid, p_lrv);
        if (p_frv) begin
            chk("f_fault", f_fault, p_fflt);
            h_f = p_fdat;
        end
        chk("f_instr", f_instr, h_f);
        if (p_lrv) h_l = p_ldat;
        chk("l_rdata", l_rdata, h_l);

        off  = pc - 32'h0000_3000;
        flt  = (off >= 32'h0000_4000);
`ifdef IM_MISALIGN_TRAP_EN
        if (pc[1:0] != 2'b00) flt = 1'b1;
`endif
        fidx = off[13:2];
        lidx = la[13:2];
        if (m_locked) begin
            eg_f = 0; eg_l = lr;
        end else if (m_rel) begin
            eg_f = fr; eg_l = 0;
        end else begin
            eg_l = lr && (!fr || m_waits == 4);
            eg_f = fr && !eg_l;
        end
        e_en = eg_l || (eg_f && !flt);
        chk("f_gnt", f_gnt, eg_f);
        chk("l_gnt", l_gnt, eg_l);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_we", mem_we, eg_l && lw);
            chk("mem_addr", mem_addr, eg_l ? lidx : fidx);
        end
        if (eg_l && lw) chk("mem_wdata", mem_wdata, wd);

        p_frv  = eg_f;
        p_fflt = eg_f && flt;
        p_fdat = flt ? 32'h0 : rd(fidx);
        p_lrv  = eg_l && !lw;
        p_ldat = rd(lidx);
        if (eg_l && lw) begin
            rmem[lidx] = wd;
            rwr[lidx]  = 1'b1;
        end

        if (m_rel || eg_l || !lr) m_waits = 0;
        else if (eg_f && m_waits < 4) m_waits++;
        if (m_locked) begin
            m_locked = lk; m_rel = !lk;
        end else begin
            m_rel = 0; m_locked = lk;
        end
    endtask

    task automatic idle();
        step(0, 32'h3000, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        int run, mx, lg;
        bit rk;
        logic [31:0] rpc, rla;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_f_instr", f_instr, 0);
        chk("rst_l_rdata", l_rdata, 0);
        chk("rst_f_fault", f_fault, 0);
        reset = 1'b1;

        // Basic fetch of a preloaded word 0.
        step(0, 32'h3000, 1, 1, 0, 32'h0, 32'h2408_0001);
        step(1, 32'h3000, 0, 0, 0, 32'h0, 32'h0);
        idle();
        chk("basic_instr_const", h_f, 32'h2408_0001);

        // Out-of-range below and above the window.
        step(1, 32'h2FFC, 0, 0, 0, 32'h0, 32'h0);
        step(1, 32'h7000, 0, 0, 0, 32'h0, 32'h0);
        idle();

        // Starvation guard with both requesters held.
        run = 0; mx = 0; lg = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 32'h3000 + 4 * i, 1, 0, 0, 32'h4 * i, 32'h0);
            if (f_gnt) run++;
            else begin
                if (run > mx) mx = run;
                run = 0;
            end
            if (l_gnt) lg++;
        end
        chk("starve_max_run", mx, 4);
        chk("starve_l_grants", lg, 3);
        idle();

        // Lock, loader write/read, release with a REL cycle, then fetch the written word.
        step(1, 32'h3000, 0, 0, 1, 32'h0, 32'h0);
        step(1, 32'h3004, 1, 1, 1, 32'h8, 32'hDEAD_BEEF);
        step(1, 32'h3004, 1, 0, 1, 32'h8, 32'h0);
        step(1, 32'h3004, 1, 0, 0, 32'h8, 32'h0);
        step(1, 32'h3008, 1, 0, 0, 32'h0, 32'h0);
        step(0, 32'h3000, 0, 0, 0, 32'h0, 32'h0);
        chk("lock_fetch_const", h_f, 32'hDEAD_BEEF);

        // Write followed immediately by a read of the same index.
        step(0, 32'h3000, 1, 1, 0, 32'h40, 32'h1234_5678);
        step(0, 32'h3000, 1, 0, 0, 32'h40, 32'h0);
        idle();

        // Misaligned fetch.
        step(1, 32'h3002, 0, 0, 0, 32'h0, 32'h0);
        idle();

        // Reset while locked with a return in flight.
        step(0, 32'h3000, 0, 0, 1, 32'h0, 32'h0);
        step(1, 32'h3000, 1, 0, 1, 32'h10, 32'h0);
        #2;
        reset = 1'b0;
        f_req = 0; l_req = 0; l_lock = 0;
        @(negedge clk);
        #1;
        chk("mrst_f_rvalid", f_rvalid, 0);
        chk("mrst_l_rvalid", l_rvalid, 0);
        chk("mrst_f_instr", f_instr, 0);
        chk("mrst_l_rdata", l_rdata, 0);
        chk("mrst_f_fault", f_fault, 0);
        chk("mrst_mem_en", mem_en, 0);
        chk("mrst_gnts", {f_gnt, l_gnt}, 0);
        reset = 1'b1;
        model_reset();
        step(0, 32'h3000, 1, 0, 0, 32'h20, 32'h0);
        step(0, 32'h3000, 1, 0, 0, 32'h24, 32'h0);
        idle();

        // Randomised traffic.
        rk = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) rk = !rk;
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;
                1:       rpc = 32'h3000 + 4 * $urandom_range(0, 4095) + $urandom_range(0, 3);
                default: rpc = 32'h3000 + 4 * $urandom_range(0, 63);
            endcase
            rla = ($urandom & 32'hFFFF_0000) | (4 * $urandom_range(0, 63)) | $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, rk, rla, $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
